// File: rtl/ms_stereo_encoder_pkg.sv
// Shared definitions for the mid/side stereo encoder stage.
// Q2.16 constants, header mode encodings, state type and saturation helper.
package ms_stereo_encoder_pkg;

    localparam int GRANULE_LINES = 576;

    localparam logic [17:0] ONE_DIV_SQRT2 = 18'h0B504;

    localparam logic [1:0] MODE_JOINT = 2'b01;

    localparam int MODE_EXT_MS = 1;

    localparam logic signed [17:0] Q216_MAX = 18'sh1FFFF;
    localparam logic signed [17:0] Q216_MIN = 18'sh20000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ANALYZE,
        ST_DECIDE,
        ST_TRANSFORM,
        ST_DONE
    } ms_state_e;

    function automatic logic [17:0] sat_q216(input logic signed [36:0] v);
        if (v > 37'(Q216_MAX)) begin
            return Q216_MAX;
        end
        if (v < 37'(Q216_MIN)) begin
            return Q216_MIN;
        end
        return v[17:0];
    endfunction

endpackage

// File: rtl/ms_stereo_encoder_butterfly.sv
// Combinational mid/side butterfly: sat(K*(L+R)), sat(K*(L-R)) in Q2.16,
// plus the magnitudes |L+R| and |L-R| used for the energy decision.
module ms_butterfly
    import ms_stereo_encoder_pkg::*;
(
    input  logic [17:0] l_i,
    input  logic [17:0] r_i,
    output logic [17:0] mid_o,
    output logic [17:0] side_o,
    output logic [18:0] mid_mag_o,
    output logic [18:0] side_mag_o
);

    logic signed [18:0] sum_w;
    logic signed [18:0] diff_w;
    logic signed [36:0] k_w;
    logic signed [36:0] mid_p;
    logic signed [36:0] side_p;

    // Widen, scale by 1/sqrt(2), drop 16 fraction bits and clamp.
    always_comb begin
        sum_w      = 19'(signed'(l_i)) + 19'(signed'(r_i));
        diff_w     = 19'(signed'(l_i)) - 19'(signed'(r_i));
        k_w        = 37'(ONE_DIV_SQRT2);
        mid_p      = 37'(sum_w) * k_w;
        side_p     = 37'(diff_w) * k_w;
        mid_o      = sat_q216(mid_p >>> 16);
        side_o     = sat_q216(side_p >>> 16);
        mid_mag_o  = sum_w[18] ? -sum_w : sum_w;
        side_mag_o = diff_w[18] ? -diff_w : diff_w;
    end

endmodule

// File: rtl/ms_stereo_encoder.sv
// In-place mid/side stereo encoder over the two granule RAMs.
// MS_ADAPTIVE_EN enables the energy analysis pass; otherwise MS is forced.
module ms_stereo_encoder
    import ms_stereo_encoder_pkg::*;
#(
    parameter int THRESH_SHIFT = 2,
    parameter int LINES        = GRANULE_LINES
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  granule_ch0_read_addr,
    input  logic [17:0] granule_ch0_read_data,
    output logic        granule_ch0_write_enable,
    output logic [9:0]  granule_ch0_write_addr,
    output logic [17:0] granule_ch0_write_data,
    output logic [9:0]  granule_ch1_read_addr,
    input  logic [17:0] granule_ch1_read_data,
    output logic        granule_ch1_write_enable,
    output logic [9:0]  granule_ch1_write_addr,
    output logic [17:0] granule_ch1_write_data,
    input  logic [1:0]  header_mode,
    output logic [1:0]  mode_extension,
    input  logic        stage_ready,
    output logic        stage_done
);

    localparam logic [9:0] LAST = 10'(LINES);

    ms_state_e   state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic        ms_w;
    logic        we_w;
    logic [17:0] mid_w;
    logic [17:0] side_w;

`ifdef MS_ADAPTIVE_EN
    logic [29:0] side_q, side_d;
    logic [29:0] mid_q, mid_d;
    logic [18:0] mid_mag_w;
    logic [18:0] side_mag_w;
`else
    localparam int unused_thresh_shift = THRESH_SHIFT;
    logic [18:0] unused_mid_mag;
    logic [18:0] unused_side_mag;
`endif

    ms_butterfly u_bfly (
        .l_i        (granule_ch0_read_data),
        .r_i        (granule_ch1_read_data),
        .mid_o      (mid_w),
        .side_o     (side_w),
`ifdef MS_ADAPTIVE_EN
        .mid_mag_o  (mid_mag_w),
        .side_mag_o (side_mag_w)
`else
        .mid_mag_o  (unused_mid_mag),
        .side_mag_o (unused_side_mag)
`endif
    );

    // State, line counter, decision and energy accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
`ifdef MS_ADAPTIVE_EN
            side_q  <= '0;
            mid_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
`ifdef MS_ADAPTIVE_EN
            side_q  <= side_d;
            mid_q   <= mid_d;
`endif
        end
    end

    // Next-state, RAM sequencing and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        ms_w       = 1'b0;
        we_w       = 1'b0;
        stage_done = 1'b0;
        granule_ch0_read_addr  = '0;
        granule_ch1_read_addr  = '0;
        granule_ch0_write_addr = '0;
        granule_ch1_write_addr = '0;
`ifdef MS_ADAPTIVE_EN
        side_d     = side_q;
        mid_d      = mid_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (stage_ready) begin
                    cnt_d  = '0;
                    mode_d = '0;
                    if (header_mode == MODE_JOINT) begin
`ifdef MS_ADAPTIVE_EN
                        state_d = ST_ANALYZE;
                        side_d  = '0;
                        mid_d   = '0;
`else
                        state_d = ST_DECIDE;
`endif
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ANALYZE: begin
                granule_ch0_read_addr = cnt_q;
                granule_ch1_read_addr = cnt_q;
`ifdef MS_ADAPTIVE_EN
                if (cnt_q != '0) begin
                    side_d = side_q + 30'(side_mag_w);
                    mid_d  = mid_q + 30'(mid_mag_w);
                end
`endif
                if (cnt_q == LAST) begin
                    state_d = ST_DECIDE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_DECIDE: begin
`ifdef MS_ADAPTIVE_EN
                ms_w = side_q < (mid_q >> THRESH_SHIFT);
`else
                ms_w = 1'b1;
`endif
                mode_d              = '0;
                mode_d[MODE_EXT_MS] = ms_w;
                cnt_d               = '0;
                state_d             = ms_w ? ST_TRANSFORM : ST_DONE;
            end
            ST_TRANSFORM: begin
                granule_ch0_read_addr = cnt_q;
                granule_ch1_read_addr = cnt_q;
                if (cnt_q != '0) begin
                    we_w = 1'b1;
                    granule_ch0_write_addr = cnt_q - 10'd1;
                    granule_ch1_write_addr = cnt_q - 10'd1;
                end
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_DONE: begin
                stage_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        granule_ch0_write_enable = we_w;
        granule_ch1_write_enable = we_w;
        granule_ch0_write_data   = we_w ? mid_w : '0;
        granule_ch1_write_data   = we_w ? side_w : '0;
    end

    assign mode_extension = mode_q;

endmodule
